memory_bus_master: RTL and testbench
====================================

# memory_bus_master

Command-driven initiator for the actuator register-file bus: converts single or burst read/write commands into the active-low `memory_enable_n` / `memory_write_n` / `memory_read_n` strobe sequence and returns read data or write acknowledges over a valid/ready response channel. It sits between the host-side command front end and the memory controller that holds `cell_state` and `ccr0`–`ccr3`. Address range checking happens here, so out-of-range commands never reach the bus.

## Interface
Parameters:
- `NUM_WORDS`, 10: number of implemented register words; valid addresses are 0..NUM_WORDS-1.
- `ADDR_W`, 8: bus address width.
- `DATA_W`, 16: bus data width.

Ports:
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid` and `cmd_ready` are both 1.
- `cmd_write`  in  1  1 = write burst, 0 = read burst.
- `cmd_addr`  in  ADDR_W  start address.
- `cmd_len`  in  4  burst length minus 1 (0 = one word).
- `wdata_valid`  in  1  write word offered.
- `wdata_ready`  out  1  write word accepted on handshake.
- `wdata`  in  DATA_W  write word.
- `rsp_valid`  out  1  response offered.
- `rsp_ready`  in  1  response consumed on handshake.
- `rsp_data`  out  DATA_W  read word; 0 for write ack or error.
- `rsp_last`  out  1  final response of the command.
- `rsp_error`  out  1  command rejected as out of range.
- `memory_enable_n`  out  1  bus enable, active low.
- `memory_write_n`  out  1  write strobe, active low.
- `memory_read_n`  out  1  read strobe, active low.
- `memory_address`  out  ADDR_W  bus address.
- `memory_data_in`  out  DATA_W  bus write data.
- `memory_data_out`  in  DATA_W  registered read data from the responder.
- `busy`  out  1  FSM not in IDLE.

## Operation
- All bus outputs are registered. Reset values: all three strobes 1; `memory_address` 0; `memory_data_in` 0; `rsp_*` 0; `wdata_ready` 0; `busy` 0; `cmd_ready` 1.
- FSM states: IDLE, WR_WAIT, WR_STROBE, RD_STROBE, RD_WAIT, RESP, ERR.
- IDLE: `cmd_ready` = 1. On handshake, latch address, remaining count and direction. If `cmd_addr + cmd_len` is greater than or equal to NUM_WORDS, go to ERR; otherwise go to WR_WAIT or RD_STROBE. The sum is computed in ADDR_W+1 bits, so it cannot wrap.
- ERR: hold one response with `rsp_error`=1, `rsp_last`=1, data 0 until `rsp_ready`, then go to IDLE. No strobe is issued.
- WR_WAIT: `wdata_ready` = 1. On handshake, go to WR_STROBE.
- WR_STROBE: for exactly one cycle, `memory_enable_n`=0, `memory_write_n`=0, address equals the current address, `memory_data_in` equals `wdata`. Then increment the address and decrement the count. If words remain, go to WR_WAIT; otherwise go to RESP, which presents an ack with `rsp_last`=1 and data 0.
- RD_STROBE: for exactly one cycle, `memory_enable_n`=0 and `memory_read_n`=0. Next state is RD_WAIT.
- RD_WAIT: strobes high. Capture `memory_data_out` into `rsp_data` at the end of this cycle, then go to RESP.
- RESP: `rsp_valid` = 1. `rsp_data`, `rsp_last` and `rsp_error` stay stable until `rsp_ready`. After the handshake:
  - read with words remaining: increment address, go to RD_STROBE;
  - otherwise: go to IDLE.
- `memory_write_n` and `memory_read_n` are never low in the same cycle. Outside strobe cycles, `memory_enable_n` is 1.
- `memory_address` and `memory_data_in` hold their last driven value between strobes.
- Reset mid-command: the command is aborted, and no response for it is ever issued.

## Timing
- Read, single word, `rsp_ready` tied to 1:
  - cycle 0: command handshake;
  - cycle 1: strobes low;
  - cycle 2: responder data valid;
  - cycle 3: `rsp_valid`.
- Read throughput: 3 cycles per word with no backpressure.
- Write, `wdata_valid` held 1:
  - cycle 0: command handshake;
  - cycle 1: `wdata_ready`;
  - cycle 2: strobe;
  - cycle 3: ack `rsp_valid` for the last word.
- Write throughput: 2 cycles per word.
- Error: `rsp_valid` in cycle 1 after the command handshake.
- `cmd_ready` returns to 1 in the cycle after the final response handshake.
- Reset: all outputs take their reset values in the cycle after the `reset` edge.

## Structure
- Shared package `memory_bus_pkg` holds:
  - the FSM state enum;
  - `NUM_WORDS` and the data and address widths;
  - word index constants: `CELL_STATE`=0, `CCR0_LO`=2 … `CCR3_HI`=9.
- Single module with no sub-module. The address counter and remaining-count counter are inline.

## Test plan
- Reset with `cmd_valid`=0: all strobes read 1, `cmd_ready`=1, `rsp_valid`=0, `busy`=0 for 5 cycles.
- Write addr 0x02, len 0, `wdata`=0x1234:
  - exactly one strobe cycle with enable_n=0, write_n=0, read_n=1, address 0x02, data 0x1234;
  - then one ack with `rsp_last`=1, `rsp_error`=0.
- Write burst addr 2, len 1, data 0x1234 then 0x5678; then read burst addr 2, len 1:
  - responses 0x1234 (`rsp_last`=0) then 0x5678 (`rsp_last`=1);
  - read strobes 3 cycles apart.
- Command addr 8, len 2 (sum 10): single response with `rsp_error`=1, `rsp_last`=1, data 0; no strobe ever low.
- Read burst of 3 words with `rsp_ready` held 0 for 5 cycles on the second response:
  - `rsp_valid` and `rsp_data` stay stable;
  - no new strobe is issued until the handshake.
- `reset` pulsed during WR_WAIT of a 4-word burst: next cycle shows strobes high, `rsp_valid`=0, `cmd_ready`=1; no further writes occur.

Source files
------------

// File: rtl/memory_bus_pkg.sv
// memory_bus_pkg
//   Shared definitions for the actuator register-file bus initiator:
//   bus geometry, register word map and the initiator FSM state encoding.
package memory_bus_pkg;

  localparam int unsigned NUM_WORDS = 10;
  localparam int unsigned ADDR_W    = 8;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned LEN_W     = 4;

  // Register word map held by the memory controller
  localparam int unsigned CELL_STATE = 0;
  localparam int unsigned CCR0_LO    = 2;
  localparam int unsigned CCR0_HI    = 3;
  localparam int unsigned CCR1_LO    = 4;
  localparam int unsigned CCR1_HI    = 5;
  localparam int unsigned CCR2_LO    = 6;
  localparam int unsigned CCR2_HI    = 7;
  localparam int unsigned CCR3_LO    = 8;
  localparam int unsigned CCR3_HI    = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_WAIT,
    ST_WR_STROBE,
    ST_RD_STROBE,
    ST_RD_WAIT,
    ST_RESP,
    ST_ERR
  } state_t;

endpackage

// File: rtl/memory_bus_master.sv
// memory_bus_master
//   Converts single/burst read and write commands into the active-low
//   enable/write/read strobe sequence of the register-file bus and returns
//   read data or write acks over a valid/ready response channel.
//   Out-of-range commands are answered with an error response and never
//   reach the bus.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   cmd_*                  command channel (valid/ready, write, addr, len-1)
//   wdata_*                write data channel (valid/ready)
//   rsp_*                  response channel (valid/ready, data, last, error)
//   memory_*               bus strobes, address, write data, read data
//   busy                   FSM not idle
module memory_bus_master
  import memory_bus_pkg::*;
#(
  parameter int unsigned NUM_WORDS = memory_bus_pkg::NUM_WORDS,
  parameter int unsigned ADDR_W    = memory_bus_pkg::ADDR_W,
  parameter int unsigned DATA_W    = memory_bus_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              rsp_error,
  output logic              memory_enable_n,
  output logic              memory_write_n,
  output logic              memory_read_n,
  output logic [ADDR_W-1:0] memory_address,
  output logic [DATA_W-1:0] memory_data_in,
  input  logic [DATA_W-1:0] memory_data_out,
  output logic              busy
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_WORDS);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                write_q, write_d;

  logic                cmd_ready_q, cmd_ready_d;
  logic                wdata_ready_q, wdata_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_last_q, rsp_last_d;
  logic                rsp_error_q, rsp_error_d;
  logic                enable_n_q, enable_n_d;
  logic                write_n_q, write_n_d;
  logic                read_n_q, read_n_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                busy_q, busy_d;

  logic                cmd_hs, wdata_hs, rsp_hs;
  logic [ADDR_W:0]     range_end;

  assign cmd_hs    = cmd_valid & cmd_ready_q;
  assign wdata_hs  = wdata_valid & wdata_ready_q;
  assign rsp_hs    = rsp_valid_q & rsp_ready;
  // One extra bit so that e.g. 0xFF + 15 cannot wrap back into range
  assign range_end = {1'b0, cmd_addr} + (ADDR_W+1)'(cmd_len);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    rsp_error_d = rsp_error_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_hs) begin
          addr_d  = cmd_addr;
          cnt_d   = cmd_len;
          write_d = cmd_write;
          if (range_end >= LIMIT) begin
            state_d     = ST_ERR;
            rsp_data_d  = '0;
            rsp_last_d  = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            state_d = cmd_write ? ST_WR_WAIT : ST_RD_STROBE;
          end
        end
      end
      ST_WR_WAIT: begin
        if (wdata_hs) begin
          state_d     = ST_WR_STROBE;
          mem_wdata_d = wdata;
        end
      end
      ST_WR_STROBE: begin
        addr_d = addr_q + 1'b1;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = ST_RESP;
          rsp_data_d  = '0;
          rsp_last_d  = 1'b1;
          rsp_error_d = 1'b0;
        end else begin
          state_d = ST_WR_WAIT;
        end
      end
      ST_RD_STROBE: begin
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        state_d     = ST_RESP;
        rsp_data_d  = memory_data_out;
        rsp_last_d  = (cnt_q == '0);
        rsp_error_d = 1'b0;
      end
      ST_RESP: begin
        if (rsp_hs) begin
          rsp_data_d  = '0;
          rsp_last_d  = 1'b0;
          rsp_error_d = 1'b0;
          // Count wraps after the final write strobe, so only reads continue
          if (!write_q && cnt_q != '0) begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q - 1'b1;
            state_d = ST_RD_STROBE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_ERR: begin
        if (rsp_hs) begin
          rsp_data_d  = '0;
          rsp_last_d  = 1'b0;
          rsp_error_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so each strobe is
    // visible in exactly the cycle the FSM spends in the strobe state.
    cmd_ready_d   = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
    wdata_ready_d = (state_d == ST_WR_WAIT);
    rsp_valid_d   = (state_d == ST_RESP) || (state_d == ST_ERR);
    write_n_d     = (state_d != ST_WR_STROBE);
    read_n_d      = (state_d != ST_RD_STROBE);
    enable_n_d    = write_n_d & read_n_d;
    mem_addr_d    = enable_n_d ? mem_addr_q : addr_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      cmd_ready_q   <= 1'b1;
      wdata_ready_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_last_q    <= 1'b0;
      rsp_error_q   <= 1'b0;
      enable_n_q    <= 1'b1;
      write_n_q     <= 1'b1;
      read_n_q      <= 1'b1;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      write_q       <= write_d;
      cmd_ready_q   <= cmd_ready_d;
      wdata_ready_q <= wdata_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_last_q    <= rsp_last_d;
      rsp_error_q   <= rsp_error_d;
      enable_n_q    <= enable_n_d;
      write_n_q     <= write_n_d;
      read_n_q      <= read_n_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      busy_q        <= busy_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign wdata_ready     = wdata_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_data        = rsp_data_q;
  assign rsp_last        = rsp_last_q;
  assign rsp_error       = rsp_error_q;
  assign memory_enable_n = enable_n_q;
  assign memory_write_n  = write_n_q;
  assign memory_read_n   = read_n_q;
  assign memory_address  = mem_addr_q;
  assign memory_data_in  = mem_wdata_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_memory_bus_master.sv
// tb_memory_bus_master
//   Directed bench for memory_bus_master: a table of commands with
//   hand-computed responses, strobe addresses/data and cycle positions,
//   plus sequences for response backpressure and reset mid-burst.
//   A small register-file responder answers strobes with registered data.
module tb_memory_bus_master;
  import memory_bus_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic        wdata_valid = 1'b0;
  logic        wdata_ready;
  logic [15:0] wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        rsp_last;
  logic        rsp_error;
  logic        memory_enable_n;
  logic        memory_write_n;
  logic        memory_read_n;
  logic [7:0]  memory_address;
  logic [15:0] memory_data_in;
  logic [15:0] memory_data_out = '0;
  logic        busy;

  always #5 clock = ~clock;

  memory_bus_master #(.NUM_WORDS(10), .ADDR_W(8), .DATA_W(16)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_last(rsp_last), .rsp_error(rsp_error),
    .memory_enable_n(memory_enable_n), .memory_write_n(memory_write_n),
    .memory_read_n(memory_read_n), .memory_address(memory_address),
    .memory_data_in(memory_data_in), .memory_data_out(memory_data_out),
    .busy(busy)
  );

  // Register-file responder with registered read data
  logic [15:0] mem [256] = '{default: '0};
  always @(posedge clock) begin
    if (!memory_enable_n && !memory_write_n) mem[memory_address] <= memory_data_in;
    if (!memory_enable_n && !memory_read_n) memory_data_out <= mem[memory_address];
  end

  int checks_total = 0;
  int checks_passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks_total++;
    if (act === exp) checks_passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  // Cycle n spans posedge n to posedge n+1
  function automatic int cyc();
    return int'(($time - 64'd5) / 64'd10);
  endfunction

  typedef struct { bit wr; logic [7:0] a; logic [15:0] d; int c; } strobe_t;
  typedef struct { logic [15:0] d; bit last; bit err; int c; } rsp_t;
  strobe_t str_q[$];
  rsp_t    rsp_q[$];

  always @(negedge clock) begin
    chk("strobe_exclusive", 64'(memory_write_n | memory_read_n), 64'd1);
    chk("enable_matches_strobes", 64'(memory_enable_n), 64'(memory_write_n & memory_read_n));
    if (!memory_enable_n)
      str_q.push_back('{wr: !memory_write_n, a: memory_address, d: memory_data_in, c: cyc()});
    if (rsp_valid && rsp_ready)
      rsp_q.push_back('{d: rsp_data, last: rsp_last, err: rsp_error, c: cyc()});
  end

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [3:0]  len;
    logic [63:0] data;  // word i in bits [16*i +: 16]: write data or expected read data
    bit          err;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [7:0] a, logic [3:0] l, logic [63:0] d, bit e);
    vec_t v;
    v.wr = wr; v.addr = a; v.len = l; v.data = d; v.err = e;
    return v;
  endfunction

  // Called just after a posedge; returns just after the handshake posedge
  task automatic send_cmd(input bit w, input logic [7:0] a, input logic [3:0] l, output int hs);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    hs = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (cmd_ready) begin hs = cyc(); break; end
    end
    if (hs < 0) chk("cmd_accept_timeout", 64'd0, 64'd1);
    else @(posedge clock);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic feed_word(input logic [15:0] d);
    bit ok = 1'b0;
    wdata_valid = 1'b1; wdata = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (wdata_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("wdata_accept_timeout", 64'd0, 64'd1);
    else @(posedge clock);
    #1 wdata_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock); #1;
      if (rsp_q.size() >= n) begin ok = 1'b1; break; end
    end
    if (!ok) chk("rsp_timeout", 64'(rsp_q.size()), 64'(n));
  endtask

  task automatic run_vector(input vec_t v, input int idx);
    int hs;
    int base_s = str_q.size();
    int base_r = rsp_q.size();
    int n_rsp  = (v.err || v.wr) ? 1 : int'(v.len) + 1;
    int n_str  = v.err ? 0 : int'(v.len) + 1;
    @(posedge clock); #1;
    send_cmd(v.wr, v.addr, v.len, hs);
    if (v.wr && !v.err)
      for (int i = 0; i <= int'(v.len); i++) feed_word(v.data[16*i +: 16]);
    wait_rsp(base_r + n_rsp);
    @(negedge clock);
    chk($sformatf("v%0d_cmd_ready_after_rsp", idx), 64'(cmd_ready), 64'd1);
    chk($sformatf("v%0d_busy_after_rsp", idx), 64'(busy), 64'd0);
    repeat (2) @(negedge clock);
    chk($sformatf("v%0d_rsp_count", idx), 64'(rsp_q.size()), 64'(base_r + n_rsp));
    chk($sformatf("v%0d_strobe_count", idx), 64'(str_q.size()), 64'(base_s + n_str));
    for (int i = 0; i < n_rsp && base_r + i < rsp_q.size(); i++) begin
      rsp_t r = rsp_q[base_r + i];
      logic [15:0] ed = (v.err || v.wr) ? 16'h0 : v.data[16*i +: 16];
      int ec = v.err ? hs + 1 : (v.wr ? hs + 3 + 2 * int'(v.len) : hs + 3 + 3 * i);
      chk($sformatf("v%0d_rsp%0d_data", idx, i), 64'(r.d), 64'(ed));
      chk($sformatf("v%0d_rsp%0d_last", idx, i), 64'(r.last), 64'(i == n_rsp - 1));
      chk($sformatf("v%0d_rsp%0d_error", idx, i), 64'(r.err), 64'(v.err));
      chk($sformatf("v%0d_rsp%0d_cycle", idx, i - 0), 64'(r.c), 64'(ec));
    end
    for (int i = 0; i < n_str && base_s + i < str_q.size(); i++) begin
      strobe_t s = str_q[base_s + i];
      int ec = v.wr ? hs + 2 + 2 * i : hs + 1 + 3 * i;
      chk($sformatf("v%0d_str%0d_dir", idx, i), 64'(s.wr), 64'(v.wr));
      chk($sformatf("v%0d_str%0d_addr", idx, i), 64'(s.a), 64'(v.addr + 8'(i)));
      chk($sformatf("v%0d_str%0d_cycle", idx, i), 64'(s.c), 64'(ec));
      if (v.wr) chk($sformatf("v%0d_str%0d_wdata", idx, i), 64'(s.d), 64'(v.data[16*i +: 16]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[12];
    int hs, base_s, base_r, s_hold;
    bit found;

    vt[0]  = mk(1'b1, 8'(CCR0_LO), 4'd0, 64'h1234, 1'b0);
    vt[1]  = mk(1'b1, 8'd2, 4'd1, 64'h5678_1234, 1'b0);
    vt[2]  = mk(1'b0, 8'd2, 4'd1, 64'h5678_1234, 1'b0);
    vt[3]  = mk(1'b1, 8'd8, 4'd1, 64'h5555_AAAA, 1'b0);
    vt[4]  = mk(1'b0, 8'd9, 4'd0, 64'h5555, 1'b0);
    vt[5]  = mk(1'b0, 8'd8, 4'd2, 64'h0, 1'b1);
    vt[6]  = mk(1'b1, 8'd10, 4'd0, 64'hBEEF, 1'b1);
    vt[7]  = mk(1'b0, 8'hFF, 4'hF, 64'h0, 1'b1);
    vt[8]  = mk(1'b1, 8'd0, 4'd3, 64'h0004_0003_0002_0001, 1'b0);
    vt[9]  = mk(1'b0, 8'd0, 4'd3, 64'h0004_0003_0002_0001, 1'b0);
    vt[10] = mk(1'b0, 8'd9, 4'd0, 64'h5555, 1'b0);
    vt[11] = mk(1'b0, 8'd6, 4'd3, 64'h5555_AAAA_0000_0000, 1'b0);

    // Reset, then idle outputs for 5 cycles
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("rst_enable_n", 64'(memory_enable_n), 64'd1);
      chk("rst_write_n", 64'(memory_write_n), 64'd1);
      chk("rst_read_n", 64'(memory_read_n), 64'd1);
      chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_wdata_ready", 64'(wdata_ready), 64'd0);
      chk("rst_address", 64'(memory_address), 64'd0);
      chk("rst_data_in", 64'(memory_data_in), 64'd0);
    end

    for (int i = 0; i < 12; i++) run_vector(vt[i], i);

    // Backpressure: hold the second of three read responses for 5 cycles
    base_s = str_q.size();
    base_r = rsp_q.size();
    @(posedge clock); #1;
    send_cmd(1'b0, 8'd0, 4'd2, hs);
    wait_rsp(base_r + 1);
    @(posedge clock); #1 rsp_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (rsp_valid) begin found = 1'b1; break; end
    end
    if (!found) chk("bp_second_rsp_timeout", 64'd0, 64'd1);
    s_hold = str_q.size();
    chk("bp_strobes_before_hold", 64'(s_hold), 64'(base_s + 2));
    chk("bp_hold0_data", 64'(rsp_data), 64'h0002);
    for (int k = 1; k < 5; k++) begin
      @(negedge clock);
      chk($sformatf("bp_hold%0d_valid", k), 64'(rsp_valid), 64'd1);
      chk($sformatf("bp_hold%0d_data", k), 64'(rsp_data), 64'h0002);
      chk($sformatf("bp_hold%0d_last", k), 64'(rsp_last), 64'd0);
    end
    chk("bp_no_strobe_during_hold", 64'(str_q.size()), 64'(s_hold));
    @(posedge clock); #1 rsp_ready = 1'b1;
    wait_rsp(base_r + 3);
    repeat (3) @(negedge clock);
    chk("bp_rsp_count", 64'(rsp_q.size()), 64'(base_r + 3));
    chk("bp_strobe_count", 64'(str_q.size()), 64'(base_s + 3));
    if (rsp_q.size() >= base_r + 3) begin
      chk("bp_rsp0_data", 64'(rsp_q[base_r].d), 64'h0001);
      chk("bp_rsp1_data", 64'(rsp_q[base_r + 1].d), 64'h0002);
      chk("bp_rsp2_data", 64'(rsp_q[base_r + 2].d), 64'h0003);
      chk("bp_rsp1_last", 64'(rsp_q[base_r + 1].last), 64'd0);
      chk("bp_rsp2_last", 64'(rsp_q[base_r + 2].last), 64'd1);
    end

    // Reset pulsed while waiting for the first word of a 4-word write
    base_s = str_q.size();
    base_r = rsp_q.size();
    @(posedge clock); #1;
    send_cmd(1'b1, 8'd0, 4'd3, hs);
    @(negedge clock);
    chk("mr_wdata_ready_before", 64'(wdata_ready), 64'd1);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("mr_enable_n", 64'(memory_enable_n), 64'd1);
    chk("mr_write_n", 64'(memory_write_n), 64'd1);
    chk("mr_read_n", 64'(memory_read_n), 64'd1);
    chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mr_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_wdata_ready", 64'(wdata_ready), 64'd0);
    #1 reset = 1'b0;
    wdata_valid = 1'b1; wdata = 16'hDEAD;
    repeat (10) @(negedge clock);
    #1 wdata_valid = 1'b0;
    chk("mr_no_writes", 64'(str_q.size()), 64'(base_s));
    chk("mr_no_response", 64'(rsp_q.size()), 64'(base_r));
    run_vector(mk(1'b0, 8'd0, 4'd0, 64'h0001, 1'b0), 99);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
